// File: rtl/speed_pkg.sv
// speed_pkg: definitions shared by the speed ramp controller and the speed counter.
//   ramp_state_e : ramp sequencer states (idle / single-cycle step / pacing wait)
//   DIR_UP/DOWN  : encoding of the counter's UP_DOWN input
package speed_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StStep = 2'd1,
    StWait = 2'd2
  } ramp_state_e;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/key_press_det.sv
// key_press_det: two-flop synchronizer and press detector for one raw active-low push-button.
// A press is the synchronized level going 1 -> 0. Each press gives exactly one single-cycle
// pulse, however long the key is held down.
//   CLK   : clock
//   RST   : asynchronous active-high reset; all flops reset to 1 (key released)
//   key_n : raw push-button, active-low, asynchronous to CLK
//   press : one-cycle pulse per press
module key_press_det (
  input  logic CLK,
  input  logic RST,
  input  logic key_n,
  output logic press
);

  logic sync1_q, sync2_q, prev_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= key_n;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  // Decoded from flops only, so the pulse is glitch-free.
  assign press = prev_q & ~sync2_q;

endmodule

// File: rtl/speed_ramp_ctrl.sv
// speed_ramp_ctrl: rate-limited sequencer for the speed up/down counter.
// Holds a target speed (set by keys or by a preset request) and walks the counter toward it one
// step at a time, with at least STEP_DIV cycles between step strobes. A shadow copy of the
// counter value gives saturation and the status outputs.
//   CLK, RST              : clock, asynchronous active-high reset
//   KEY1 / KEY2           : raw active-low keys; a press decrements / increments the target
//   PRESET_REQ/PRESET_VAL : one-cycle request to load a clamped target
//   HOLD                  : stops new steps; the target still updates
//   ENABLE, UP_DOWN       : registered step strobe and direction to the counter
//   SPEED                 : shadow of the counter value
//   BUSY, AT_MIN, AT_MAX  : registered status computed from the post-update values
module speed_ramp_ctrl
  import speed_pkg::*;
#(
  parameter int unsigned WIDTH       = 4,
  parameter int unsigned MIN_SPEED   = 0,
  parameter int unsigned MAX_SPEED   = 15,
  parameter int unsigned RESET_SPEED = 0,
  parameter int unsigned STEP_DIV    = 25_000_000
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             KEY1,
  input  logic             KEY2,
  input  logic             PRESET_REQ,
  input  logic [WIDTH-1:0] PRESET_VAL,
  input  logic             HOLD,
  output logic             ENABLE,
  output logic             UP_DOWN,
  output logic [WIDTH-1:0] SPEED,
  output logic             BUSY,
  output logic             AT_MIN,
  output logic             AT_MAX
);

  localparam logic [WIDTH-1:0] MinSpeed   = WIDTH'(MIN_SPEED);
  localparam logic [WIDTH-1:0] MaxSpeed   = WIDTH'(MAX_SPEED);
  localparam logic [WIDTH-1:0] ResetSpeed = WIDTH'(RESET_SPEED);
  localparam logic [WIDTH-1:0] One        = WIDTH'(1);
  localparam int unsigned      PaceW      = $clog2(STEP_DIV);
  // STEP takes one cycle and WAIT runs PaceInit+1 cycles: strobes are STEP_DIV apart.
  localparam logic [PaceW-1:0] PaceInit   = PaceW'(STEP_DIV - 2);

  // Compared in int so that bounds at the ends of the WIDTH range stay well defined.
  function automatic logic [WIDTH-1:0] clamp_speed(input logic [WIDTH-1:0] v);
    if (int'(v) < int'(MIN_SPEED)) return MinSpeed;
    if (int'(v) > int'(MAX_SPEED)) return MaxSpeed;
    return v;
  endfunction

  logic up_ev, dn_ev;

  key_press_det u_key_dn (
    .CLK   (CLK),
    .RST   (RST),
    .key_n (KEY1),
    .press (dn_ev)
  );

  key_press_det u_key_up (
    .CLK   (CLK),
    .RST   (RST),
    .key_n (KEY2),
    .press (up_ev)
  );

  ramp_state_e      state_q, state_d;
  logic [PaceW-1:0] pace_q, pace_d;
  logic [WIDTH-1:0] target_q, target_d;
  logic [WIDTH-1:0] speed_q, speed_d;
  logic             enable_q, enable_d;
  logic             up_down_q, up_down_d;
  logic             busy_q, at_min_q, at_max_q;
  logic             want_step;

  // Target register; a preset takes priority over keys, and simultaneous keys cancel out.
  always_comb begin
    target_d = target_q;
    if (PRESET_REQ) begin
      target_d = clamp_speed(PRESET_VAL);
    end else if (up_ev && !dn_ev) begin
      if (target_q < MaxSpeed) target_d = target_q + One;
    end else if (dn_ev && !up_ev) begin
      if (target_q > MinSpeed) target_d = target_q - One;
    end
  end

  assign want_step = (target_q != speed_q) && !HOLD;

  always_comb begin
    state_d   = state_q;
    pace_d    = pace_q;
    speed_d   = speed_q;
    enable_d  = 1'b0;
    up_down_d = up_down_q;
    unique case (state_q)
      StIdle: begin
        if (want_step) begin
          state_d   = StStep;
          enable_d  = 1'b1;
          up_down_d = (target_q < speed_q) ? DIR_DOWN : DIR_UP;
        end
      end
      StStep: begin
        // Follow the direction actually strobed to the counter so the shadow stays in lockstep.
        if (up_down_q == DIR_DOWN) begin
          if (speed_q > MinSpeed) speed_d = speed_q - One;
        end else begin
          if (speed_q < MaxSpeed) speed_d = speed_q + One;
        end
        pace_d  = PaceInit;
        state_d = StWait;
      end
      StWait: begin
        if (pace_q == '0) begin
          if (want_step) begin
            state_d   = StStep;
            enable_d  = 1'b1;
            up_down_d = (target_q < speed_q) ? DIR_DOWN : DIR_UP;
          end else begin
            state_d = StIdle;
          end
        end else begin
          pace_d = pace_q - PaceW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= StIdle;
      pace_q    <= '0;
      target_q  <= ResetSpeed;
      speed_q   <= ResetSpeed;
      enable_q  <= 1'b0;
      up_down_q <= DIR_UP;
      busy_q    <= 1'b0;
      at_min_q  <= (ResetSpeed == MinSpeed);
      at_max_q  <= (ResetSpeed == MaxSpeed);
    end else begin
      state_q   <= state_d;
      pace_q    <= pace_d;
      target_q  <= target_d;
      speed_q   <= speed_d;
      enable_q  <= enable_d;
      up_down_q <= up_down_d;
      busy_q    <= (target_d != speed_d);
      at_min_q  <= (speed_d == MinSpeed);
      at_max_q  <= (speed_d == MaxSpeed);
    end
  end

  assign ENABLE  = enable_q;
  assign UP_DOWN = up_down_q;
  assign SPEED   = speed_q;
  assign BUSY    = busy_q;
  assign AT_MIN  = at_min_q;
  assign AT_MAX  = at_max_q;

endmodule
